// File: rtl/configf_pkg.sv
// Shared types and constants for the serial config-engine command arbiter.
package configf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GRANT = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  localparam int DEF_GAP_CYCLES     = 8;
  localparam int DEF_TIMEOUT_CYCLES = 1024;
  localparam int ADDR_WR_BIT        = 7;

endpackage

// File: rtl/configf_rr_pick.sv
// Combinational round-robin picker: search starts one above the last-served index.
module configf_rr_pick
  import configf_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_idx,
  output logic [NUM_REQ-1:0] win_onehot,
  output logic [IDX_W-1:0]   win_idx,
  output logic               win_vld
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;

  always_comb begin
    win_onehot = '0;
    win_idx    = '0;
    win_vld    = 1'b0;
    cand       = 0;
    cand_idx   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = int'(last_idx) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!win_vld && req[cand_idx]) begin
        win_vld              = 1'b1;
        win_idx              = cand_idx;
        win_onehot[cand_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/configf_arbiter.sv
// Round-robin arbiter serialising requester commands onto one config engine.
// Optional watchdog on the engine response enabled by `define CONFIGF_TIMEOUT_EN.
module configf_arbiter
  import configf_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_in,
  input  logic [NUM_REQ*8-1:0]   req_addr_in,
  input  logic [NUM_REQ*16-1:0]  req_data_in,
  output logic [NUM_REQ-1:0]     grant_out,
  output logic [NUM_REQ-1:0]     done_out,
  output logic [NUM_REQ-1:0]     err_out,
  output logic                   entity_cmd_en_out,
  output logic [7:0]             entity_addr_out,
  output logic [15:0]            entity_wrrd_num_out,
  input  logic                   entity_cmd_done_in,
  output logic                   busy_out
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t             state;
  logic [IDX_W-1:0]   last_idx;
  logic [IDX_W-1:0]   win_idx;
  logic [NUM_REQ-1:0] win_onehot;
  logic               win_vld;
  logic [7:0]         gap_cnt;
  logic [7:0]         sel_addr;
  logic [15:0]        sel_data;

`ifdef CONFIGF_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0]   tmo_cnt;
  logic [NUM_REQ-1:0] err_q;
  assign err_out = err_q;
`else
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT_CYCLES != 0);
  assign err_out    = '0;
`endif

  configf_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req        (req_in),
    .last_idx   (last_idx),
    .win_onehot (win_onehot),
    .win_idx    (win_idx),
    .win_vld    (win_vld)
  );

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_onehot[i]) begin
        sel_addr = req_addr_in[i*8 +: 8];
        sel_data = req_data_in[i*16 +: 16];
      end
    end
  end

  assign busy_out = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state               <= ST_IDLE;
      grant_out           <= '0;
      done_out            <= '0;
      entity_cmd_en_out   <= 1'b0;
      entity_addr_out     <= '0;
      entity_wrrd_num_out <= '0;
      last_idx            <= IDX_W'(NUM_REQ - 1);
      gap_cnt             <= '0;
`ifdef CONFIGF_TIMEOUT_EN
      tmo_cnt             <= '0;
      err_q               <= '0;
`endif
    end else begin
      done_out          <= '0;
      entity_cmd_en_out <= 1'b0;
`ifdef CONFIGF_TIMEOUT_EN
      err_q             <= '0;
`endif
      case (state)
        // Accept: latch the winner so later requester changes cannot leak through
        ST_IDLE: begin
          if (win_vld) begin
            state               <= ST_GRANT;
            grant_out           <= win_onehot;
            last_idx            <= win_idx;
            entity_addr_out     <= sel_addr;
            entity_wrrd_num_out <= sel_data;
          end
        end
        ST_GRANT: begin
          state             <= ST_ISSUE;
          entity_cmd_en_out <= 1'b1;
        end
        ST_ISSUE: begin
          state <= ST_WAIT;
`ifdef CONFIGF_TIMEOUT_EN
          tmo_cnt <= '0;
`endif
        end
        // Done has priority over a watchdog expiry on the same cycle
        ST_WAIT: begin
          if (entity_cmd_done_in) begin
            done_out  <= grant_out;
            grant_out <= '0;
            state     <= ST_GAP;
            gap_cnt   <= 8'(GAP_CYCLES - 1);
          end
`ifdef CONFIGF_TIMEOUT_EN
          else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            err_q     <= grant_out;
            grant_out <= '0;
            state     <= ST_GAP;
            gap_cnt   <= 8'(GAP_CYCLES - 1);
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        ST_GAP: begin
          if (gap_cnt == 8'd0) state <= ST_IDLE;
          else                 gap_cnt <= gap_cnt - 8'd1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_configf_arbiter.sv
// Scoreboard bench for configf_arbiter: expected commands queued at stimulus, popped at cmd strobe.
module tb_configf_arbiter;

  localparam int NUM_REQ = 4;
  localparam int GAP     = 8;
`ifdef CONFIGF_TIMEOUT_EN
  localparam int TMO        = 16;
  localparam int SINGLE_DLY = 10;
`else
  localparam int TMO        = 1024;
  localparam int SINGLE_DLY = 40;
`endif

  logic                  clk;
  logic                  reset;
  logic [NUM_REQ-1:0]    req_in;
  logic [NUM_REQ*8-1:0]  req_addr_in;
  logic [NUM_REQ*16-1:0] req_data_in;
  logic [NUM_REQ-1:0]    grant_out;
  logic [NUM_REQ-1:0]    done_out;
  logic [NUM_REQ-1:0]    err_out;
  logic                  entity_cmd_en_out;
  logic [7:0]            entity_addr_out;
  logic [15:0]           entity_wrrd_num_out;
  logic                  entity_cmd_done_in;
  logic                  busy_out;

  typedef struct {
    logic [NUM_REQ-1:0] grant;
    logic [7:0]         addr;
    logic [15:0]        data;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  configf_arbiter #(
    .NUM_REQ        (NUM_REQ),
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .req_in              (req_in),
    .req_addr_in         (req_addr_in),
    .req_data_in         (req_data_in),
    .grant_out           (grant_out),
    .done_out            (done_out),
    .err_out             (err_out),
    .entity_cmd_en_out   (entity_cmd_en_out),
    .entity_addr_out     (entity_addr_out),
    .entity_wrrd_num_out (entity_wrrd_num_out),
    .entity_cmd_done_in  (entity_cmd_done_in),
    .busy_out            (busy_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_cmd(output bit ok);
    int n = 0;
    while (!entity_cmd_en_out && n < 300) begin
      tick();
      n++;
    end
    ok = entity_cmd_en_out;
  endtask

  task automatic wait_idle(output bit ok);
    int n = 0;
    while (busy_out && n < 300) begin
      tick();
      n++;
    end
    ok = !busy_out;
  endtask

  task automatic set_req(input int i, input logic [7:0] a, input logic [15:0] d);
    req_addr_in[i*8 +: 8]   = a;
    req_data_in[i*16 +: 16] = d;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_in = '0; entity_cmd_done_in = 1'b0;
    req_addr_in = '0; req_data_in = '0;
    tick(); tick();
    n_checks++;
    if ({grant_out, done_out, err_out, entity_cmd_en_out, busy_out} !== '0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got grant=%b done=%b err=%b cmd_en=%b busy=%b, want all 0",
               grant_out, done_out, err_out, entity_cmd_en_out, busy_out);
    end
    n_checks++;
    if ({entity_addr_out, entity_wrrd_num_out} !== 24'h0) begin
      n_fail++;
      $display("FAIL reset_data: got addr=%h num=%h, want 0/0", entity_addr_out, entity_wrrd_num_out);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single();
    exp_t e;
    bit   stray = 0;
    bit   ok;
    set_req(2, 8'h85, 16'h1234);
    req_in = 4'b0100;
    sb.push_back('{4'b0100, 8'h85, 16'h1234});
    tick();
    n_checks++;
    if (entity_cmd_en_out !== 1'b0 || grant_out !== 4'b0100 || busy_out !== 1'b1) begin
      n_fail++;
      $display("FAIL single_grant: got cmd_en=%b grant=%b busy=%b, want 0/0100/1",
               entity_cmd_en_out, grant_out, busy_out);
    end
    tick();
    e = sb.pop_front();
    n_checks++;
    if (entity_cmd_en_out !== 1'b1 || {grant_out, entity_addr_out, entity_wrrd_num_out} !== {e.grant, e.addr, e.data}) begin
      n_fail++;
      $display("FAIL single_issue: got cmd_en=%b grant=%b addr=%h num=%h, want 1/%b/%h/%h",
               entity_cmd_en_out, grant_out, entity_addr_out, entity_wrrd_num_out, e.grant, e.addr, e.data);
    end
    tick();
    n_checks++;
    if (entity_cmd_en_out !== 1'b0) begin
      n_fail++;
      $display("FAIL single_strobe_width: cmd_en=%b one cycle after issue, want 0", entity_cmd_en_out);
    end
    for (int i = 0; i < SINGLE_DLY - 1; i++) begin
      tick();
      if (done_out !== '0 || err_out !== '0 || grant_out !== 4'b0100) stray = 1;
    end
    n_checks++;
    if (stray) begin
      n_fail++;
      $display("FAIL single_wait_hold: got stray done/err or lost grant during WAIT, want none");
    end
    entity_cmd_done_in = 1'b1;
    tick();
    entity_cmd_done_in = 1'b0;
    n_checks++;
    if (done_out !== 4'b0100 || grant_out !== 4'b0000 || err_out !== 4'b0000) begin
      n_fail++;
      $display("FAIL single_done: got done=%b grant=%b err=%b, want 0100/0000/0000",
               done_out, grant_out, err_out);
    end
    tick();
    n_checks++;
    if (done_out !== 4'b0000) begin
      n_fail++;
      $display("FAIL single_done_pulse: done=%b one cycle later, want 0000", done_out);
    end
    req_in = '0;
    wait_idle(ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL single_idle: busy=%b after bound, want 0", busy_out);
    end
  endtask

  task automatic test_round_robin();
    exp_t e;
    bit   ok;
    int   last_done = -1;
    reset = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 8'(8'h10 + i), 16'(16'hA000 + i));
    req_in = 4'b1111;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      e.grant = 4'b0001 << (k % NUM_REQ);
      e.addr  = 8'(8'h10 + (k % NUM_REQ));
      e.data  = 16'(16'hA000 + (k % NUM_REQ));
      sb.push_back(e);
    end
    for (int k = 0; k < 5; k++) begin
      wait_cmd(ok);
      e = sb.pop_front();
      n_checks++;
      if (!ok || {grant_out, entity_addr_out, entity_wrrd_num_out} !== {e.grant, e.addr, e.data}) begin
        n_fail++;
        $display("FAIL rr_order[%0d]: got cmd_en=%b grant=%b addr=%h num=%h, want 1/%b/%h/%h",
                 k, entity_cmd_en_out, grant_out, entity_addr_out, entity_wrrd_num_out, e.grant, e.addr, e.data);
      end
      if (last_done >= 0) begin
        n_checks++;
        if (cyc - last_done != GAP + 2) begin
          n_fail++;
          $display("FAIL rr_gap[%0d]: cmd_en %0d cycles after done, want %0d", k, cyc - last_done, GAP + 2);
        end
      end
      repeat (4) tick();
      entity_cmd_done_in = 1'b1;
      tick();
      entity_cmd_done_in = 1'b0;
      last_done = cyc;
      if (k == 4) req_in = '0;
      n_checks++;
      if (done_out !== e.grant) begin
        n_fail++;
        $display("FAIL rr_done[%0d]: got done=%b, want %b", k, done_out, e.grant);
      end
    end
    wait_idle(ok);
  endtask

  task automatic test_data_hold();
    exp_t e;
    bit   ok;
    set_req(1, 8'h81, 16'h00FF);
    req_in = 4'b0010;
    sb.push_back('{4'b0010, 8'h81, 16'h00FF});
    wait_cmd(ok);
    e = sb.pop_front();
    n_checks++;
    if (!ok || {grant_out, entity_addr_out, entity_wrrd_num_out} !== {e.grant, e.addr, e.data}) begin
      n_fail++;
      $display("FAIL hold_issue: got grant=%b addr=%h num=%h, want %b/%h/%h",
               grant_out, entity_addr_out, entity_wrrd_num_out, e.grant, e.addr, e.data);
    end
    tick();
    set_req(1, 8'h22, 16'hAAAA);
    repeat (5) tick();
    n_checks++;
    if (entity_wrrd_num_out !== 16'h00FF || entity_addr_out !== 8'h81) begin
      n_fail++;
      $display("FAIL hold_stable: got addr=%h num=%h, want 81/00ff", entity_addr_out, entity_wrrd_num_out);
    end
    req_in = '0;
    entity_cmd_done_in = 1'b1;
    tick();
    entity_cmd_done_in = 1'b0;
    n_checks++;
    if (done_out !== 4'b0010) begin
      n_fail++;
      $display("FAIL hold_done_after_drop: got done=%b, want 0010", done_out);
    end
    wait_idle(ok);
  endtask

  task automatic test_spurious();
    bit ok;
    int t_done;
    entity_cmd_done_in = 1'b1;
    tick();
    entity_cmd_done_in = 1'b0;
    tick();
    n_checks++;
    if (done_out !== '0 || busy_out !== 1'b0 || grant_out !== '0) begin
      n_fail++;
      $display("FAIL spur_idle: got done=%b busy=%b grant=%b, want 0/0/0", done_out, busy_out, grant_out);
    end
    set_req(0, 8'h05, 16'h0007);
    req_in = 4'b0001;
    wait_cmd(ok);
    req_in = '0;
    tick();
    entity_cmd_done_in = 1'b1;
    tick();
    entity_cmd_done_in = 1'b0;
    t_done = cyc;
    tick();
    entity_cmd_done_in = 1'b1;
    tick();
    entity_cmd_done_in = 1'b0;
    n_checks++;
    if (done_out !== '0 || busy_out !== 1'b1) begin
      n_fail++;
      $display("FAIL spur_gap: got done=%b busy=%b during GAP, want 0/1", done_out, busy_out);
    end
    wait_idle(ok);
    n_checks++;
    if (!ok || cyc - t_done != GAP) begin
      n_fail++;
      $display("FAIL gap_length: IDLE %0d cycles after done, want %0d", cyc - t_done, GAP);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    bit   ok;
    set_req(0, 8'h11, 16'h2222);
    req_in = 4'b0001;
    wait_cmd(ok);
    tick(); tick();
    reset = 1'b1;
    tick();
    n_checks++;
    if ({grant_out, done_out, err_out, entity_cmd_en_out, busy_out, entity_addr_out, entity_wrrd_num_out} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: got grant=%b done=%b err=%b cmd_en=%b busy=%b addr=%h num=%h, want all 0",
               grant_out, done_out, err_out, entity_cmd_en_out, busy_out, entity_addr_out, entity_wrrd_num_out);
    end
    reset = 1'b0;
    req_in = '0;
    tick(); tick();
    n_checks++;
    if (done_out !== '0 || err_out !== '0 || busy_out !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_quiet: got done=%b err=%b busy=%b, want 0/0/0", done_out, err_out, busy_out);
    end
    set_req(3, 8'h43, 16'h3C3C);
    req_in = 4'b1000;
    sb.push_back('{4'b1000, 8'h43, 16'h3C3C});
    tick();
    n_checks++;
    if (entity_cmd_en_out !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_lat1: cmd_en=%b one cycle after req, want 0", entity_cmd_en_out);
    end
    tick();
    e = sb.pop_front();
    n_checks++;
    if (entity_cmd_en_out !== 1'b1 || {grant_out, entity_addr_out, entity_wrrd_num_out} !== {e.grant, e.addr, e.data}) begin
      n_fail++;
      $display("FAIL post_reset_issue: got cmd_en=%b grant=%b addr=%h num=%h, want 1/%b/%h/%h",
               entity_cmd_en_out, grant_out, entity_addr_out, entity_wrrd_num_out, e.grant, e.addr, e.data);
    end
    req_in = '0;
    tick();
    entity_cmd_done_in = 1'b1;
    tick();
    entity_cmd_done_in = 1'b0;
    n_checks++;
    if (done_out !== 4'b1000) begin
      n_fail++;
      $display("FAIL post_reset_done: got done=%b, want 1000", done_out);
    end
    wait_idle(ok);
  endtask

`ifdef CONFIGF_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    bit stray = 0;
    set_req(0, 8'h01, 16'h0001);
    req_in = 4'b0001;
    wait_cmd(ok);
    req_in = '0;
    tick();
    for (int i = 0; i < TMO - 1; i++) begin
      tick();
      if (err_out !== '0 || done_out !== '0) stray = 1;
    end
    tick();
    n_checks++;
    if (stray || err_out !== 4'b0001 || done_out !== '0 || grant_out !== '0) begin
      n_fail++;
      $display("FAIL timeout_err: early=%b got err=%b done=%b grant=%b, want 0/0001/0000/0000",
               stray, err_out, done_out, grant_out);
    end
    wait_idle(ok);
    req_in = 4'b0001;
    wait_cmd(ok);
    req_in = '0;
    tick();
    repeat (TMO - 1) tick();
    entity_cmd_done_in = 1'b1;
    tick();
    entity_cmd_done_in = 1'b0;
    n_checks++;
    if (done_out !== 4'b0001 || err_out !== '0) begin
      n_fail++;
      $display("FAIL timeout_tie: got done=%b err=%b, want 0001/0000", done_out, err_out);
    end
    wait_idle(ok);
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_data_hold();
    test_spurious();
    test_reset_mid();
`ifdef CONFIGF_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
